// File: rtl/trace_arb_pkg.sv
// Shared types and width helpers for the trace stream arbiter.
package trace_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Occupancy needs one extra bit to represent a completely full FIFO.
  function automatic int unsigned fill_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/trace_sync_fifo.sv
// Single-clock FIFO holding {last, word} entries for one trace channel.
module trace_sync_fifo
  import trace_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        push_i,
  input  logic [WIDTH-1:0]            din_i,
  input  logic                        pop_i,
  output logic [WIDTH-1:0]            dout_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [fill_w(DEPTH)-1:0]    fill_o
);

  localparam int unsigned AW = ptr_w(DEPTH);
  localparam int unsigned FW = fill_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [FW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign full_o  = (r_count == FW'(DEPTH));
  assign empty_o = (r_count == '0);
  assign fill_o  = r_count;
  assign dout_o  = r_mem[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + FW'(1);
      else if (!w_push && w_pop) r_count <= r_count - FW'(1);
    end
  end

  // Storage is not reset; contents are only observable once pushed.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= din_i;
  end

endmodule

// File: rtl/trace_stream_arbiter.sv
// Round-robin, packet-atomic merge of NUM_CH trace streams onto one output.
// Optional macro TRACE_ARB_CH_ID_EN adds the packet_ch_o source-channel output.
module trace_stream_arbiter
  import trace_arb_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NUM_CH*WORD_W-1:0]              word_i,
  input  logic [NUM_CH-1:0]                     word_valid_i,
  input  logic [NUM_CH-1:0]                     word_last_i,
  output logic [NUM_CH-1:0]                     word_ready_o,
  output logic [WORD_W-1:0]                     packet_word_o,
  output logic                                  packet_word_valid_o,
  output logic                                  packet_word_last_o,
  input  logic                                  stall_i,
  output logic [NUM_CH*fill_w(FIFO_DEPTH)-1:0]  fill_o
`ifdef TRACE_ARB_CH_ID_EN
  ,
  output logic [$clog2(NUM_CH)-1:0]             packet_ch_o
`endif
);

  localparam int unsigned CH_W = $clog2(NUM_CH);
  localparam int unsigned FW   = fill_w(FIFO_DEPTH);
  localparam int unsigned EW   = WORD_W + 1;

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic [CH_W-1:0]  r_grant;
  logic [CH_W-1:0]  w_grant_nxt;
  logic [CH_W-1:0]  r_rr_ptr;
  logic [CH_W-1:0]  w_rr_nxt;
  logic [CH_W-1:0]  w_sel;
  logic [CH_W-1:0]  w_idx;
  logic [CH_W-1:0]  w_grant_inc;
  logic             w_any;
  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_empty;
  logic [EW-1:0]    w_head [NUM_CH];
  logic [EW-1:0]    w_gnt_head;
  logic             w_out_valid;
  logic             w_pop_any;

  for (genvar gc = 0; gc < NUM_CH; gc++) begin : g_ch
    logic w_push;
    logic w_pop;
    assign w_push = word_valid_i[gc] && !w_full[gc];
    assign w_pop  = w_pop_any && (r_grant == CH_W'(gc));

    trace_sync_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (w_push),
      .din_i   ({word_last_i[gc], word_i[gc*WORD_W +: WORD_W]}),
      .pop_i   (w_pop),
      .dout_o  (w_head[gc]),
      .full_o  (w_full[gc]),
      .empty_o (w_empty[gc]),
      .fill_o  (fill_o[gc*FW +: FW])
    );
  end

  // Ready depends only on full, so a full FIFO never accepts even while popping.
  assign word_ready_o        = ~w_full;
  assign w_gnt_head          = w_head[r_grant];
  assign w_out_valid         = (r_state == ST_GRANT) && !w_empty[r_grant];
  assign w_pop_any           = w_out_valid && !stall_i;
  assign packet_word_valid_o = w_out_valid;
  assign packet_word_o       = w_out_valid ? w_gnt_head[WORD_W-1:0] : '0;
  assign packet_word_last_o  = w_out_valid && w_gnt_head[WORD_W];
  assign w_grant_inc         = (r_grant == CH_W'(NUM_CH - 1)) ? '0 : r_grant + CH_W'(1);

  // First non-empty channel at or after rr_ptr, wrapping modulo NUM_CH.
  always_comb begin
    w_any = 1'b0;
    w_sel = r_rr_ptr;
    w_idx = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      w_idx = CH_W'((32'(r_rr_ptr) + k) % NUM_CH);
      if (!w_any && !w_empty[w_idx]) begin
        w_any = 1'b1;
        w_sel = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_rr_nxt    = r_rr_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_GRANT;
          w_grant_nxt = w_sel;
        end
      end
      ST_GRANT: begin
        if (w_pop_any && w_gnt_head[WORD_W]) begin
          w_state_nxt = ST_IDLE;
          w_rr_nxt    = w_grant_inc;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_nxt;
    end
  end

`ifdef TRACE_ARB_CH_ID_EN
  assign packet_ch_o = (r_state == ST_GRANT) ? r_grant : '0;
`endif

endmodule

// File: tb/tb_trace_stream_arbiter.sv
// Directed bench for trace_stream_arbiter (NUM_CH=2, WORD_W=32, FIFO_DEPTH=8).
module tb_trace_stream_arbiter;

  localparam int unsigned NUM_CH     = 2;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned FIFO_DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] word;
  logic [1:0]  vld;
  logic [1:0]  lst;
  logic [1:0]  ready;
  logic [31:0] pw;
  logic        pv;
  logic        pl;
  logic        stall;
  logic [7:0]  fill;
`ifdef TRACE_ARB_CH_ID_EN
  logic [0:0]  pch;
`endif

  always #5 clk = ~clk;

  trace_stream_arbiter #(
    .NUM_CH     (NUM_CH),
    .WORD_W     (WORD_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .word_i              (word),
    .word_valid_i        (vld),
    .word_last_i         (lst),
    .word_ready_o        (ready),
    .packet_word_o       (pw),
    .packet_word_valid_o (pv),
    .packet_word_last_o  (pl),
    .stall_i             (stall),
    .fill_o              (fill)
`ifdef TRACE_ARB_CH_ID_EN
    ,
    .packet_ch_o         (pch)
`endif
  );

  typedef struct packed {
    logic [1:0]  vld;
    logic [1:0]  lst;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        stall;
    logic        ev;
    logic [31:0] ew;
    logic        el;
    logic [3:0]  f0;
    logic [3:0]  f1;
  } vec_t;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] l,
                       input logic [31:0] a, input logic [31:0] b, input logic s);
    vld   = v;
    lst   = l;
    word  = {b, a};
    stall = s;
  endtask

  task automatic check_out(input string tag, input logic ev, input logic [31:0] ew,
                           input logic el, input logic [3:0] f0, input logic [3:0] f1,
                           input logic [1:0] er);
    chk({tag, ".valid"}, 64'(pv), 64'(ev));
    chk({tag, ".word"},  64'(pw), 64'(ew));
    chk({tag, ".last"},  64'(pl), 64'(el));
    chk({tag, ".fill0"}, 64'(fill[3:0]), 64'(f0));
    chk({tag, ".fill1"}, 64'(fill[7:4]), 64'(f1));
    chk({tag, ".ready"}, 64'(ready), 64'(er));
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    drive(2'b00, 2'b00, 32'h0, 32'h0, 1'b0);
    step();
    step();
    check_out(tag, 1'b0, 32'h0, 1'b0, 4'd0, 4'd0, 2'b11);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [19];
    logic [31:0] rr_exp [8];
    int          got;

    // Contention, single word + rr_ptr advance, and a stalled final word.
    tbl[0]  = '{2'b11, 2'b00, 32'hA000_0000, 32'hB000_0000, 1'b0, 1'b0, 32'h0,         1'b0, 4'd1, 4'd1};
    tbl[1]  = '{2'b11, 2'b00, 32'hA000_0001, 32'hB000_0001, 1'b0, 1'b1, 32'hA000_0000, 1'b0, 4'd2, 4'd2};
    tbl[2]  = '{2'b11, 2'b11, 32'hA000_0002, 32'hB000_0002, 1'b0, 1'b1, 32'hA000_0001, 1'b0, 4'd2, 4'd3};
    tbl[3]  = '{2'b00, 2'b00, 32'h0,         32'h0,         1'b0, 1'b1, 32'hA000_0002, 1'b1, 4'd1, 4'd3};
    tbl[4]  = '{2'b00, 2'b00, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 4'd0, 4'd3};
    tbl[5]  = '{2'b00, 2'b00, 32'h0,         32'h0,         1'b0, 1'b1, 32'hB000_0000, 1'b0, 4'd0, 4'd3};
    tbl[6]  = '{2'b00, 2'b00, 32'h0,         32'h0,         1'b0, 1'b1, 32'hB000_0001, 1'b0, 4'd0, 4'd2};
    tbl[7]  = '{2'b00, 2'b00, 32'h0,         32'h0,         1'b0, 1'b1, 32'hB000_0002, 1'b1, 4'd0, 4'd1};
    tbl[8]  = '{2'b00, 2'b00, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 4'd0, 4'd0};
    tbl[9]  = '{2'b00, 2'b00, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 4'd0, 4'd0};
    tbl[10] = '{2'b01, 2'b01, 32'hDEAD_BEEF, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 4'd1, 4'd0};
    tbl[11] = '{2'b00, 2'b00, 32'h0,         32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 4'd1, 4'd0};
    tbl[12] = '{2'b00, 2'b00, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 4'd0, 4'd0};
    tbl[13] = '{2'b11, 2'b11, 32'hC000_0000, 32'hD000_0000, 1'b0, 1'b0, 32'h0,         1'b0, 4'd1, 4'd1};
    tbl[14] = '{2'b00, 2'b00, 32'h0,         32'h0,         1'b0, 1'b1, 32'hD000_0000, 1'b1, 4'd1, 4'd1};
    tbl[15] = '{2'b00, 2'b00, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 4'd1, 4'd0};
    tbl[16] = '{2'b00, 2'b00, 32'h0,         32'h0,         1'b0, 1'b1, 32'hC000_0000, 1'b1, 4'd1, 4'd0};
    tbl[17] = '{2'b00, 2'b00, 32'h0,         32'h0,         1'b1, 1'b1, 32'hC000_0000, 1'b1, 4'd1, 4'd0};
    tbl[18] = '{2'b00, 2'b00, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 4'd0, 4'd0};

    rr_exp = '{32'h100, 32'h200, 32'h101, 32'h201, 32'h102, 32'h202, 32'h103, 32'h203};

    rst = 1'b1;
    drive(2'b00, 2'b00, 32'h0, 32'h0, 1'b0);
    do_reset("reset");

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].vld, tbl[i].lst, tbl[i].w0, tbl[i].w1, tbl[i].stall);
      step();
      check_out($sformatf("tbl[%0d]", i), tbl[i].ev, tbl[i].ew, tbl[i].el,
                tbl[i].f0, tbl[i].f1, 2'b11);
    end

    // Stall mid-packet, ch1 fills to depth, then ch0 starves before its last word.
    do_reset("reset2");
    drive(2'b01, 2'b00, 32'hE000_0000, 32'h0, 1'b0);
    step();
    check_out("stl_p0", 1'b0, 32'h0, 1'b0, 4'd1, 4'd0, 2'b11);
    drive(2'b01, 2'b00, 32'hE000_0001, 32'h0, 1'b0);
    step();
    check_out("stl_p1", 1'b1, 32'hE000_0000, 1'b0, 4'd2, 4'd0, 2'b11);
    for (int k = 0; k < 8; k++) begin
      drive(2'b10, (k == 7) ? 2'b10 : 2'b00, 32'h0, 32'h6000_0000 + 32'(k), (k < 4));
      step();
      if (k < 4)
        check_out($sformatf("stl_k%0d", k), 1'b1, 32'hE000_0000, 1'b0, 4'd2, 4'(k + 1), 2'b11);
      else if (k == 4)
        check_out($sformatf("stl_k%0d", k), 1'b1, 32'hE000_0001, 1'b0, 4'd1, 4'(k + 1), 2'b11);
      else
        check_out($sformatf("stl_k%0d", k), 1'b0, 32'h0, 1'b0, 4'd0, 4'(k + 1),
                  {(k < 7), 1'b1});
    end
    drive(2'b10, 2'b10, 32'h0, 32'h6FFF_FFFF, 1'b0);
    step();
    check_out("full_rej", 1'b0, 32'h0, 1'b0, 4'd0, 4'd8, 2'b01);
    drive(2'b00, 2'b00, 32'h0, 32'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      check_out($sformatf("starve%0d", k), 1'b0, 32'h0, 1'b0, 4'd0, 4'd8, 2'b01);
    end
    drive(2'b01, 2'b01, 32'hE000_0002, 32'h0, 1'b0);
    step();
    check_out("stl_last", 1'b1, 32'hE000_0002, 1'b1, 4'd1, 4'd8, 2'b01);
    drive(2'b00, 2'b00, 32'h0, 32'h0, 1'b0);
    step();
    check_out("stl_idle", 1'b0, 32'h0, 1'b0, 4'd0, 4'd8, 2'b01);
    for (int k = 0; k < 8; k++) begin
      step();
      check_out($sformatf("drain%0d", k), 1'b1, 32'h6000_0000 + 32'(k), (k == 7),
                4'd0, 4'(8 - k), {(k != 0), 1'b1});
    end
    step();
    check_out("drain_end", 1'b0, 32'h0, 1'b0, 4'd0, 4'd0, 2'b11);

    // Reset after the second of four words, then a fresh ch1 packet.
    drive(2'b01, 2'b00, 32'h7000_0000, 32'h0, 1'b0);
    step();
    check_out("mid_p0", 1'b0, 32'h0, 1'b0, 4'd1, 4'd0, 2'b11);
    drive(2'b01, 2'b00, 32'h7000_0001, 32'h0, 1'b0);
    step();
    check_out("mid_p1", 1'b1, 32'h7000_0000, 1'b0, 4'd2, 4'd0, 2'b11);
    rst = 1'b1;
    drive(2'b00, 2'b00, 32'h0, 32'h0, 1'b0);
    step();
    check_out("mid_rst", 1'b0, 32'h0, 1'b0, 4'd0, 4'd0, 2'b11);
    rst = 1'b0;
    drive(2'b10, 2'b10, 32'h0, 32'h8000_0000, 1'b0);
    step();
    check_out("post_p", 1'b0, 32'h0, 1'b0, 4'd0, 4'd1, 2'b11);
    drive(2'b00, 2'b00, 32'h0, 32'h0, 1'b0);
    step();
    check_out("post_g", 1'b1, 32'h8000_0000, 1'b1, 4'd0, 4'd1, 2'b11);
`ifdef TRACE_ARB_CH_ID_EN
    chk("post_ch", 64'(pch), 64'd1);
`endif
    step();
    check_out("post_i", 1'b0, 32'h0, 1'b0, 4'd0, 4'd0, 2'b11);

    // Both channels stream 1-word packets; grants must alternate.
    got = 0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      if (cyc < 4) drive(2'b11, 2'b11, 32'h100 + 32'(cyc), 32'h200 + 32'(cyc), 1'b0);
      else         drive(2'b00, 2'b00, 32'h0, 32'h0, 1'b0);
      step();
      if (pv && got < 8) begin
        chk($sformatf("rr_word%0d", got), 64'(pw), 64'(rr_exp[got]));
`ifdef TRACE_ARB_CH_ID_EN
        chk($sformatf("rr_ch%0d", got), 64'(pch), 64'(got % 2));
`endif
        got++;
      end
    end
    chk("rr_count", 64'(got), 64'd8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
